// File: rtl/echo_range_processor_pkg.sv
// Shared types and constants for the echo range processing pipeline.
package echo_range_processor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DIVIDE  = 3'd1,
    ST_AVERAGE = 3'd2,
    ST_CONVERT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int CYCLES_PER_CM_DEF = 2900;
  localparam int MAX_CM_DEF        = 400;
  localparam int BCD_W             = 4;
  localparam int BCD_DIGITS        = 3;
  localparam int CM_W              = 10;
  localparam int DD_W              = BCD_DIGITS * BCD_W + CM_W;

  // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift left.
  function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
    logic [DD_W-1:0] a;
    a = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (a[CM_W + i*BCD_W +: BCD_W] >= 4'd5) begin
        a[CM_W + i*BCD_W +: BCD_W] = a[CM_W + i*BCD_W +: BCD_W] + 4'd3;
      end else begin
        a[CM_W + i*BCD_W +: BCD_W] = a[CM_W + i*BCD_W +: BCD_W];
      end
    end
    return {a[DD_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/echo_range_processor_seq_divider.sv
// Restoring shift-subtract divider by a constant, one quotient bit per cycle.
// The first bit is produced on the start edge, so W bits take exactly W cycles;
// done pulses in the cycle after the last bit and the quotient then holds.
module echo_range_processor_seq_divider #(
  parameter int W       = 21,
  parameter int DIVISOR = 2900
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int           CNT_W   = $clog2(W + 1);
  localparam logic [W:0]   DIV_EXT = (W+1)'(DIVISOR);

  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  logic [W-1:0] step_rem_in_s, step_quo_in_s;
  logic [W-1:0] step_rem_s, step_quo_s;
  logic [W:0]   shifted_s;
  logic         fits_s;

  // Single restoring step; starts from a clean remainder when idle.
  always_comb begin
    if (run_q) begin
      step_rem_in_s = rem_q;
      step_quo_in_s = quo_q;
    end else begin
      step_rem_in_s = '0;
      step_quo_in_s = dividend;
    end
    shifted_s = {step_rem_in_s, step_quo_in_s[W-1]};
    fits_s    = (shifted_s >= DIV_EXT);
    if (fits_s) begin
      step_rem_s = W'(shifted_s - DIV_EXT);
    end else begin
      step_rem_s = shifted_s[W-1:0];
    end
    step_quo_s = {step_quo_in_s[W-2:0], fits_s};
  end

  // Iteration control and done pulse generation.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (run_q) begin
      rem_d = step_rem_s;
      quo_d = step_quo_s;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        run_d  = 1'b1;
      end
    end else if (start) begin
      rem_d = step_rem_s;
      quo_d = step_quo_s;
      cnt_d = CNT_W'(W - 1);
      run_d = 1'b1;
    end else begin
      run_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/echo_range_processor.sv
// Converts a raw echo width to centimetres, smooths it with a power-of-two
// moving average, and presents BCD digits plus a hysteretic near flag.
module echo_range_processor
  import echo_range_processor_pkg::*;
#(
  parameter int COUNT_W       = 21,
  parameter int CYCLES_PER_CM = CYCLES_PER_CM_DEF,
  parameter int AVG_LOG2      = 2,
  parameter int MAX_CM        = MAX_CM_DEF,
  parameter int NEAR_ON       = 20,
  parameter int NEAR_OFF      = 25
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [COUNT_W-1:0] echo_count,
  input  logic               sample_valid,
  output logic               busy,
  output logic               out_valid,
  output logic [CM_W-1:0]    distance_cm,
  output logic [BCD_W-1:0]   bcd_hundreds,
  output logic [BCD_W-1:0]   bcd_tens,
  output logic [BCD_W-1:0]   bcd_ones,
  output logic               near,
  output logic               out_of_range
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SUM_W = CM_W + AVG_LOG2;

  state_e state_q, state_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [CM_W-1:0]   dist_q, dist_d;
  logic [BCD_W-1:0]  bcd_h_q, bcd_h_d, bcd_t_q, bcd_t_d, bcd_o_q, bcd_o_d;
  logic              near_q, near_d;
  logic              oor_q, oor_d;
  logic [CM_W-1:0]   sample_cm_q, sample_cm_d;
  logic              raw_oor_q, raw_oor_d;
  logic [CM_W-1:0]   avg_q, avg_d;
  logic [CM_W-1:0]   ring_q [DEPTH];
  logic [CM_W-1:0]   ring_d [DEPTH];
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              primed_q, primed_d;
  logic [DD_W-1:0]   dd_q, dd_d;
  logic [3:0]        dd_cnt_q, dd_cnt_d;

  logic               div_start_s;
  logic               div_done_s;
  logic [COUNT_W-1:0] div_quo_s;
  logic [CM_W-1:0]    avg_s;

  // New samples are only taken when the pipeline is idle.
  assign div_start_s = (state_q == ST_IDLE) && sample_valid;

  echo_range_processor_seq_divider #(
    .W       (COUNT_W),
    .DIVISOR (CYCLES_PER_CM)
  ) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start_s),
    .dividend (echo_count),
    .done     (div_done_s),
    .quotient (div_quo_s)
  );

  // Next-state logic for the sequencer, averaging buffer and output registers.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    dist_d      = dist_q;
    bcd_h_d     = bcd_h_q;
    bcd_t_d     = bcd_t_q;
    bcd_o_d     = bcd_o_q;
    near_d      = near_q;
    oor_d       = oor_q;
    sample_cm_d = sample_cm_q;
    raw_oor_d   = raw_oor_q;
    avg_d       = avg_q;
    ring_d      = ring_q;
    sum_d       = sum_q;
    ptr_d       = ptr_q;
    primed_d    = primed_q;
    dd_d        = dd_q;
    dd_cnt_d    = dd_cnt_q;
    avg_s       = avg_q;

    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          busy_d  = 1'b1;
          state_d = ST_DIVIDE;
        end else begin
          busy_d  = 1'b0;
        end
      end

      ST_DIVIDE: begin
        if (div_done_s) begin
          if (div_quo_s > COUNT_W'(MAX_CM)) begin
            sample_cm_d = CM_W'(MAX_CM);
            raw_oor_d   = 1'b1;
          end else begin
            sample_cm_d = div_quo_s[CM_W-1:0];
            raw_oor_d   = 1'b0;
          end
          state_d = ST_AVERAGE;
        end else begin
          state_d = ST_DIVIDE;
        end
      end

      ST_AVERAGE: begin
        if (primed_q) begin
          ring_d[ptr_q] = sample_cm_q;
          sum_d = sum_q - SUM_W'(ring_q[ptr_q]) + SUM_W'(sample_cm_q);
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            ring_d[i] = sample_cm_q;
          end
          sum_d    = SUM_W'(sample_cm_q) << AVG_LOG2;
          primed_d = 1'b1;
        end
        if (ptr_q == PTR_W'(DEPTH - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
        avg_s    = CM_W'(sum_d >> AVG_LOG2);
        avg_d    = avg_s;
        dd_d     = {{(BCD_DIGITS*BCD_W){1'b0}}, avg_s};
        dd_cnt_d = 4'd10;
        state_d  = ST_CONVERT;
      end

      ST_CONVERT: begin
        dd_d     = dd_step(dd_q);
        dd_cnt_d = dd_cnt_q - 4'd1;
        if (dd_cnt_q == 4'd1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CONVERT;
        end
      end

      ST_DONE: begin
        dist_d      = avg_q;
        bcd_h_d     = dd_q[CM_W + 2*BCD_W +: BCD_W];
        bcd_t_d     = dd_q[CM_W + BCD_W +: BCD_W];
        bcd_o_d     = dd_q[CM_W +: BCD_W];
        oor_d       = raw_oor_q;
        if (!near_q && (avg_q < CM_W'(NEAR_ON))) begin
          near_d = 1'b1;
        end else if (near_q && (avg_q >= CM_W'(NEAR_OFF))) begin
          near_d = 1'b0;
        end else begin
          near_d = near_q;
        end
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      dist_q      <= '0;
      bcd_h_q     <= '0;
      bcd_t_q     <= '0;
      bcd_o_q     <= '0;
      near_q      <= 1'b0;
      oor_q       <= 1'b0;
      sample_cm_q <= '0;
      raw_oor_q   <= 1'b0;
      avg_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= '0;
      end
      sum_q       <= '0;
      ptr_q       <= '0;
      primed_q    <= 1'b0;
      dd_q        <= '0;
      dd_cnt_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      dist_q      <= dist_d;
      bcd_h_q     <= bcd_h_d;
      bcd_t_q     <= bcd_t_d;
      bcd_o_q     <= bcd_o_d;
      near_q      <= near_d;
      oor_q       <= oor_d;
      sample_cm_q <= sample_cm_d;
      raw_oor_q   <= raw_oor_d;
      avg_q       <= avg_d;
      ring_q      <= ring_d;
      sum_q       <= sum_d;
      ptr_q       <= ptr_d;
      primed_q    <= primed_d;
      dd_q        <= dd_d;
      dd_cnt_q    <= dd_cnt_d;
    end
  end

  assign busy         = busy_q;
  assign out_valid    = out_valid_q;
  assign distance_cm  = dist_q;
  assign bcd_hundreds = bcd_h_q;
  assign bcd_tens     = bcd_t_q;
  assign bcd_ones     = bcd_o_q;
  assign near         = near_q;
  assign out_of_range = oor_q;

endmodule

// File: tb/tb_echo_range_processor.sv
// Directed bench: instance A uses the default 4-deep average, instance B has no averaging.
module tb_echo_range_processor;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        sel;
  logic        sv_a, sv_b;
  logic [20:0] echo_a, echo_b;

  logic       busy_a, ov_a, near_a, oor_a;
  logic [9:0] dist_a;
  logic [3:0] h_a, t_a, o_a;
  logic       busy_b, ov_b, near_b, oor_b;
  logic [9:0] dist_b;
  logic [3:0] h_b, t_b, o_b;

  logic       m_busy, m_ov, m_near, m_oor;
  logic [9:0] m_dist;
  logic [3:0] m_h, m_t, m_o;

  int tests = 0;
  int fails = 0;

  echo_range_processor dut_a (
    .clock(clock), .reset(reset), .echo_count(echo_a), .sample_valid(sv_a),
    .busy(busy_a), .out_valid(ov_a), .distance_cm(dist_a),
    .bcd_hundreds(h_a), .bcd_tens(t_a), .bcd_ones(o_a),
    .near(near_a), .out_of_range(oor_a)
  );

  echo_range_processor #(.AVG_LOG2(0)) dut_b (
    .clock(clock), .reset(reset), .echo_count(echo_b), .sample_valid(sv_b),
    .busy(busy_b), .out_valid(ov_b), .distance_cm(dist_b),
    .bcd_hundreds(h_b), .bcd_tens(t_b), .bcd_ones(o_b),
    .near(near_b), .out_of_range(oor_b)
  );

  assign m_busy = sel ? busy_b : busy_a;
  assign m_ov   = sel ? ov_b   : ov_a;
  assign m_near = sel ? near_b : near_a;
  assign m_oor  = sel ? oor_b  : oor_a;
  assign m_dist = sel ? dist_b : dist_a;
  assign m_h    = sel ? h_b    : h_a;
  assign m_t    = sel ? t_b    : t_a;
  assign m_o    = sel ? o_b    : o_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [20:0] v);
    @(negedge clock);
    if (sel) begin
      echo_b = v;
      sv_b   = 1'b1;
    end else begin
      echo_a = v;
      sv_a   = 1'b1;
    end
    @(negedge clock);
    sv_a = 1'b0;
    sv_b = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (m_ov === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic sample(input string tag, input logic [20:0] v, input int exp_cm);
    int k;
    strobe(v);
    wait_valid(k);
    check({tag, " latency"}, k, 33);
    check({tag, " cm"}, m_dist, exp_cm);
  endtask

  task automatic check_bcd(input string tag, input int h, input int t, input int o);
    check({tag, " hundreds"}, m_h, h);
    check({tag, " tens"}, m_t, t);
    check({tag, " ones"}, m_o, o);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clock);
      if (m_ov === 1'b1) n++;
    end
  endtask

  initial begin
    int k;
    int n;
    reset  = 1'b1;
    sel    = 1'b0;
    sv_a   = 1'b0;
    sv_b   = 1'b0;
    echo_a = '0;
    echo_b = '0;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst busy", m_busy, 0);
    check("rst out_valid", m_ov, 0);
    check("rst cm", m_dist, 0);
    check("rst near", m_near, 0);
    check("rst oor", m_oor, 0);
    check_bcd("rst", 0, 0, 0);
    reset = 1'b0;

    // Basic 10 cm sample with exact latency
    sample("t1", 21'd29000, 10);
    check_bcd("t1", 0, 1, 0);
    check("t1 near", m_near, 1);
    check("t1 oor", m_oor, 0);
    check("t1 busy", m_busy, 0);
    @(negedge clock);
    check("t1 pulse width", m_ov, 0);
    check("t1 hold cm", m_dist, 10);

    // Moving average
    do_reset();
    sample("t2 s1", 21'd290000, 100);
    sample("t2 s2", 21'd290000, 100);
    sample("t2 s3", 21'd290000, 100);
    sample("t2 s4", 21'd290000, 100);
    check("t2 near", m_near, 0);
    sample("t2 s5", 21'd580000, 125);
    check_bcd("t2", 1, 2, 5);

    // Saturation and out-of-range
    do_reset();
    sample("t3 sat", 21'd2000000, 400);
    check_bcd("t3 sat", 4, 0, 0);
    check("t3 oor", m_oor, 1);
    sample("t3 next", 21'd58000, 305);
    check("t3 oor clear", m_oor, 0);
    check_bcd("t3 next", 3, 0, 5);

    // Strobe while busy is ignored
    do_reset();
    strobe(21'd29000);
    repeat (4) @(negedge clock);
    check("t5 busy", m_busy, 1);
    strobe(21'd290000);
    wait_valid(k);
    check("t5 latency", k, 27);
    check("t5 cm", m_dist, 10);
    count_pulses(40, n);
    check("t5 single pulse", n, 0);
    sample("t5 follow", 21'd290000, 32);

    // Reset in the middle of DIVIDE
    strobe(21'd290000);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t6 busy", m_busy, 0);
    check("t6 out_valid", m_ov, 0);
    check("t6 cm", m_dist, 0);
    check("t6 near", m_near, 0);
    check("t6 oor", m_oor, 0);
    check_bcd("t6", 0, 0, 0);
    count_pulses(40, n);
    check("t6 no pulse", n, 0);
    sample("t6 reprime", 21'd29000, 10);

    // Near hysteresis without averaging
    sel = 1'b1;
    do_reset();
    sample("t4 30", 21'd87000, 30);
    check("t4 near 30", m_near, 0);
    sample("t4 19", 21'd55100, 19);
    check("t4 near 19", m_near, 1);
    sample("t4 22", 21'd63800, 22);
    check("t4 near 22", m_near, 1);
    sample("t4 24", 21'd69600, 24);
    check("t4 near 24", m_near, 1);
    sample("t4 25", 21'd72500, 25);
    check("t4 near 25", m_near, 0);
    sample("t4 19b", 21'd55100, 19);
    check("t4 near 19b", m_near, 1);

    // Truncation boundaries and zero echo
    sample("b 2899", 21'd2899, 0);
    sample("b 2900", 21'd2900, 1);
    sample("b zero", 21'd0, 0);
    check("b zero oor", m_oor, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
